// File: rtl/cas_recorder_if.sv
// CAS RAM write port shared by the cassette recorder and the RAM arbiter.
interface cas_recorder_if #(
   parameter int unsigned ADDR_W = 18
) ();
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              wr_en;
   logic              wr_wait;

   modport master (output wr_addr, output wr_data, output wr_en, input wr_wait);
   modport slave  (input wr_addr, input wr_data, input wr_en, output wr_wait);
endinterface

// File: rtl/cas_recorder.sv
// Decodes the SVI-328 FSK cassette output into bytes and writes a playback-compatible
// CAS image (leader, sync, data) into the CAS RAM.
module cas_recorder #(
   parameter int unsigned ADDR_W     = 18,
   parameter int unsigned SHORT_MAX  = 417,
   parameter int unsigned LONG_MAX   = 800,
   parameter int unsigned GAP_TICKS  = 4000,
   parameter int unsigned LEADER_MIN = 64,
   parameter int unsigned LEADER_OUT = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            ce_i,
   input  logic            tape_i,
   input  logic            motor_n_i,
   input  logic            record_i,
   input  logic            clear_i,
   cas_recorder_if.master  wr,
   output logic [ADDR_W:0] length_o,
   output logic            active_o,
   output logic [7:0]      err_cnt_o,
   output logic            overflow_o
);

   typedef enum logic [1:0] {StHunt, StPreamble, StStart, StData} state_e;

   logic        tape_q;
   logic [11:0] cnt_q, cnt_d;
   logic        en, rise, gap;
   logic        is_short, is_long, is_inv;
   logic        pend_q, pend_d;
   logic        bit_vld, bit_val, err_inc;

   always_comb begin
      en       = record_i & ~motor_n_i;
      rise     = ce_i & tape_i & ~tape_q;
      gap      = ce_i & ~rise & (cnt_q == 12'(GAP_TICKS - 1));
      is_short = rise & (cnt_q < 12'(SHORT_MAX));
      is_inv   = rise & (cnt_q >= 12'(LONG_MAX));
      is_long  = rise & ~is_short & ~is_inv;
      cnt_d    = cnt_q;
      if (ce_i) begin
         if (rise) begin
            cnt_d = 12'd1;
         end else if (cnt_q != 12'hfff) begin
            cnt_d = cnt_q + 12'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tape_q <= 1'b0;
         cnt_q  <= '0;
      end else if (ce_i) begin
         tape_q <= tape_i;
         cnt_q  <= cnt_d;
      end
   end

   // A one is two short periods, a zero is one long period.
   always_comb begin
      bit_vld = 1'b0;
      bit_val = 1'b0;
      err_inc = 1'b0;
      pend_d  = pend_q;
      if (!en || gap) begin
         pend_d = 1'b0;
      end else if (is_short) begin
         if (pend_q) begin
            bit_vld = 1'b1;
            bit_val = 1'b1;
            pend_d  = 1'b0;
         end else begin
            pend_d = 1'b1;
         end
      end else if (is_long) begin
         bit_vld = 1'b1;
         if (pend_q) begin
            pend_d  = 1'b0;
            err_inc = 1'b1;
         end
      end else if (is_inv) begin
         pend_d  = 1'b0;
         err_inc = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q    <= 1'b0;
         err_cnt_o <= '0;
      end else begin
         pend_q <= pend_d;
         if (clear_i) begin
            err_cnt_o <= '0;
         end else if (err_inc && err_cnt_o != 8'hff) begin
            err_cnt_o <= err_cnt_o + 8'd1;
         end
      end
   end

   state_e      state_q;
   logic [6:0]  shreg_q;
   logic [7:0]  shreg_nx;
   logic        prev_bit_q;
   logic [7:0]  alt_cnt_q;
   logic        leader_ok_q;
   logic [7:0]  pre_cnt_q;
   logic [2:0]  bit_cnt_q;
   logic        start_seen_q;
   logic        push_q;
   logic [7:0]  push_data_q;

   assign shreg_nx = {shreg_q, bit_val};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StHunt;
         shreg_q      <= '0;
         prev_bit_q   <= 1'b0;
         alt_cnt_q    <= '0;
         leader_ok_q  <= 1'b0;
         pre_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         start_seen_q <= 1'b0;
         push_q       <= 1'b0;
         push_data_q  <= '0;
         active_o     <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (bit_vld) begin
            shreg_q <= shreg_nx[6:0];
         end
         if (!en || gap) begin
            // Any partially assembled byte is simply abandoned here.
            state_q      <= StHunt;
            alt_cnt_q    <= '0;
            leader_ok_q  <= 1'b0;
            prev_bit_q   <= 1'b0;
            start_seen_q <= 1'b0;
            active_o     <= 1'b0;
         end else begin
            unique case (state_q)
               StHunt: begin
                  if (alt_cnt_q >= 8'(LEADER_MIN)) begin
                     leader_ok_q <= 1'b1;
                  end
                  if (bit_vld) begin
                     prev_bit_q <= bit_val;
                     if (bit_val != prev_bit_q) begin
                        if (alt_cnt_q != 8'hff) begin
                           alt_cnt_q <= alt_cnt_q + 8'd1;
                        end
                     end else begin
                        alt_cnt_q <= '0;
                     end
                     if (leader_ok_q && shreg_nx == 8'h7f) begin
                        state_q      <= StPreamble;
                        pre_cnt_q    <= '0;
                        start_seen_q <= 1'b0;
                     end
                  end
               end
               StPreamble: begin
                  push_q      <= 1'b1;
                  push_data_q <= (pre_cnt_q == 8'(LEADER_OUT)) ? 8'h7f : 8'h55;
                  pre_cnt_q   <= pre_cnt_q + 8'd1;
                  if (bit_vld && !bit_val) begin
                     start_seen_q <= 1'b1;
                  end
                  if (pre_cnt_q == 8'(LEADER_OUT)) begin
                     active_o  <= 1'b1;
                     bit_cnt_q <= '0;
                     // A start bit that landed mid-preamble must not be lost.
                     state_q   <= (start_seen_q || (bit_vld && !bit_val)) ? StData : StStart;
                  end
               end
               StStart: begin
                  if (bit_vld && !bit_val) begin
                     state_q   <= StData;
                     bit_cnt_q <= '0;
                  end
               end
               StData: begin
                  if (bit_vld) begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        push_q      <= 1'b1;
                        push_data_q <= shreg_nx;
                        state_q     <= StStart;
                     end
                  end
               end
               default: state_q <= StHunt;
            endcase
         end
      end
   end

   logic [7:0]      mem_q [4];
   logic [2:0]      wptr_q, rptr_q;
   logic [ADDR_W:0] ptr_q;
   logic            fifo_empty, fifo_full, img_full, pop;

   always_comb begin
      fifo_empty = (wptr_q == rptr_q);
      fifo_full  = (wptr_q[2] != rptr_q[2]) && (wptr_q[1:0] == rptr_q[1:0]);
      img_full   = ptr_q[ADDR_W];
      pop        = ~fifo_empty & ~wr.wr_wait & ~img_full & ~clear_i;
      wr.wr_en   = pop;
      wr.wr_addr = ptr_q[ADDR_W-1:0];
      wr.wr_data = mem_q[rptr_q[1:0]];
      length_o   = ptr_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q     <= '0;
         rptr_q     <= '0;
         ptr_q      <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (push_q && !fifo_full) begin
            mem_q[wptr_q[1:0]] <= push_data_q;
            wptr_q             <= wptr_q + 3'd1;
         end
         // Flush on clear or once the image is full; queued bytes have nowhere to go.
         if (clear_i || img_full) begin
            rptr_q <= wptr_q;
         end else if (pop) begin
            rptr_q <= rptr_q + 3'd1;
         end
         if (clear_i) begin
            ptr_q <= '0;
         end else if (pop) begin
            ptr_q <= ptr_q + 1'b1;
         end
         if (clear_i) begin
            overflow_o <= 1'b0;
         end else if (img_full || (push_q && fifo_full)) begin
            overflow_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cas_recorder.sv
// Directed bench for cas_recorder: scaled FSK timing, 32-byte image to reach the full boundary.
module tb_cas_recorder;

   localparam int unsigned AW = 5;
   localparam int          SP = 6;   // short period, below SHORT_MAX=9
   localparam int          LP = 12;  // long period, 9..15

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          ce = 1'b0;
   logic          tape = 1'b0;
   logic          motor_n = 1'b1;
   logic          record = 1'b0;
   logic          clear = 1'b0;
   logic [AW:0]   length;
   logic          active;
   logic [7:0]    err_cnt;
   logic          overflow;

   int            tests = 0;
   int            fails = 0;
   int            wr_total = 0;
   int            base;
   logic [7:0]    ram [32];
   logic [7:0]    s4_bytes [5];

   cas_recorder_if #(.ADDR_W(AW)) wr_if ();

   cas_recorder #(
      .ADDR_W    (AW),
      .SHORT_MAX (9),
      .LONG_MAX  (16),
      .GAP_TICKS (40),
      .LEADER_MIN(64),
      .LEADER_OUT(16)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce_i      (ce),
      .tape_i    (tape),
      .motor_n_i (motor_n),
      .record_i  (record),
      .clear_i   (clear),
      .wr        (wr_if),
      .length_o  (length),
      .active_o  (active),
      .err_cnt_o (err_cnt),
      .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_if.wr_en) begin
         ram[wr_if.wr_addr] <= wr_if.wr_data;
         wr_total           <= wr_total + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One ce tick spread over two clocks so ce gating is exercised.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         ce = 1'b1;
         @(posedge clk);
         #1 ce = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic period(input int n);
      tape = 1'b1;
      tick(n / 2);
      tape = 1'b0;
      tick(n - n / 2);
   endtask

   task automatic send_bit(input logic b);
      if (b) begin
         period(SP);
         period(SP);
      end else begin
         period(LP);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i]);
      end
   endtask

   task automatic leader(input int n);
      for (int i = 0; i < n; i++) begin
         send_bit((i % 2) == 0);
      end
   endtask

   // Closing edge for the last period; the trailing low is long enough to read as invalid.
   task automatic close_edge();
      tape = 1'b1;
      tick(3);
      tape = 1'b0;
      tick(20);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
   endtask

   initial begin
      s4_bytes[0] = 8'h11;
      s4_bytes[1] = 8'h22;
      s4_bytes[2] = 8'h33;
      s4_bytes[3] = 8'h44;
      s4_bytes[4] = 8'h55;
      wr_if.wr_wait = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_len", 32'(length), 0);
      check("rst_active", 32'(active), 0);
      check("rst_err", 32'(err_cnt), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_wr_en", 32'(wr_if.wr_en), 0);
      check("rst_wr_addr", 32'(wr_if.wr_addr), 0);
      check("rst_wr_data", 32'(wr_if.wr_data), 0);

      // Full record: leader, sync, one data byte.
      motor_n = 1'b0;
      record  = 1'b1;
      pulse_clear();
      tick(30);
      base = wr_total;
      leader(100);
      send_byte(8'h7f);
      send_bit(1'b0);
      send_byte(8'ha5);
      close_edge();
      check("s1_len", 32'(length), 18);
      check("s1_writes", 32'(wr_total - base), 18);
      for (int i = 0; i < 16; i++) begin
         check("s1_leader", 32'(ram[i]), 32'h55);
      end
      check("s1_sync", 32'(ram[16]), 32'h7f);
      check("s1_data", 32'(ram[17]), 32'ha5);
      check("s1_active", 32'(active), 1);
      check("s1_err", 32'(err_cnt), 1);  // the edge ending the idle period
      check("s1_ovf", 32'(overflow), 0);
      tick(30);
      check("s1_gap_active", 32'(active), 0);

      // Leader too short: sync must be refused.
      record = 1'b0;
      tick(2);
      record = 1'b1;
      pulse_clear();
      base = wr_total;
      leader(40);
      send_byte(8'h7f);
      send_bit(1'b0);
      send_byte(8'ha5);
      close_edge();
      tick(30);
      check("s2_writes", 32'(wr_total - base), 0);
      check("s2_len", 32'(length), 0);
      check("s2_active", 32'(active), 0);

      // Framing errors and mid-byte gap while synced.
      pulse_clear();
      leader(100);
      send_byte(8'h7f);
      send_bit(1'b0);
      send_byte(8'h3c);
      tape = 1'b1;
      tick(10);
      pulse_clear();
      base = wr_total;
      tape = 1'b0;
      tick(10);
      period(SP);
      period(LP);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      close_edge();
      check("s3_err", 32'(err_cnt), 2);
      check("s3_active_mid", 32'(active), 1);
      tick(30);
      check("s3_gap_active", 32'(active), 0);
      check("s3_gap_len", 32'(length), 0);
      check("s3_gap_writes", 32'(wr_total - base), 0);
      leader(100);
      send_byte(8'h7f);
      close_edge();
      check("s3_resync_len", 32'(length), 17);
      check("s3_resync_sync", 32'(ram[16]), 32'h7f);
      check("s3_resync_active", 32'(active), 1);

      // RAM stalled while five bytes arrive: FIFO keeps four.
      pulse_clear();
      wr_if.wr_wait = 1'b1;
      base = wr_total;
      for (int i = 0; i < 5; i++) begin
         send_bit(1'b0);
         send_byte(s4_bytes[i]);
      end
      close_edge();
      check("s4_ovf", 32'(overflow), 1);
      check("s4_len_stalled", 32'(length), 0);
      check("s4_writes_stalled", 32'(wr_total - base), 0);
      wr_if.wr_wait = 1'b0;
      tick(4);
      check("s4_len", 32'(length), 4);
      check("s4_writes", 32'(wr_total - base), 4);
      check("s4_first", 32'(ram[0]), 32'h11);
      check("s4_last", 32'(ram[3]), 32'h44);
      tick(30);

      // Image capacity boundary, then clear.
      pulse_clear();
      base = wr_total;
      leader(100);
      send_byte(8'h7f);
      for (int i = 0; i < 20; i++) begin
         send_bit(1'b0);
         send_byte(8'hc0 + 8'(i));
      end
      close_edge();
      check("s5_len", 32'(length), 32);
      check("s5_ovf", 32'(overflow), 1);
      check("s5_writes", 32'(wr_total - base), 32);
      check("s5_first_data", 32'(ram[17]), 32'hc0);
      check("s5_last_addr", 32'(ram[31]), 32'hce);
      check("s5_err_nonzero", 32'(err_cnt != 8'd0), 1);
      tick(30);
      pulse_clear();
      check("clr_len", 32'(length), 0);
      check("clr_err", 32'(err_cnt), 0);
      check("clr_ovf", 32'(overflow), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
